mul_rs: RTL

Reservation station for the multiply/divide path. It sits directly upstream of the mul/div execution unit. It holds up to three issued MUL/DIV instructions and captures operands from the common data bus (CDB) as they are broadcast. It then dispatches the oldest ready instruction to the single execution unit and frees that entry when the unit reports completion.

---
 rtl/mul_rs.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mul_rs.sv
// -----------------------------------------------------------------------------
// mul_rs : reservation station for the multiply/divide execution unit.
//
// Holds up to ENTRIES issued MUL/DIV instructions, captures missing operands
// from the common data bus, dispatches the oldest READY entry to the single
// execution unit and frees that entry when the unit reports completion.
//
// Ports
//   clk1, rst_n                    clock, synchronous active-low reset
//   iss_valid / iss_ready          issue handshake
//   iss_func, iss_rd, iss_rob      function code, destination reg, ROB tag
//   iss_v1/2, iss_d1/2, iss_q1/2   operand valid flag, value, producer tag
//   cdb_valid, cdb_rob, cdb_data   result broadcast
//   ex_busy                        execution unit occupied
//   ex_start, ex_*                 registered dispatch pulse and payload
//   ex_done, ex_done_index         completion report from the unit
//   count                          occupied entries
//   illegal_func                   pulse after an issue with a bad func code
// -----------------------------------------------------------------------------
module mul_rs #(
    parameter int ENTRIES = 3,
    parameter int DW      = 8,
    parameter int TAGW    = 3,
    parameter int RW      = 4
) (
    input  logic            clk1,
    input  logic            rst_n,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [3:0]      iss_func,
    input  logic [RW-1:0]   iss_rd,
    input  logic [TAGW-1:0] iss_rob,
    input  logic            iss_v1,
    input  logic            iss_v2,
    input  logic [DW-1:0]   iss_d1,
    input  logic [DW-1:0]   iss_d2,
    input  logic [TAGW-1:0] iss_q1,
    input  logic [TAGW-1:0] iss_q2,
    input  logic            cdb_valid,
    input  logic [TAGW-1:0] cdb_rob,
    input  logic [DW-1:0]   cdb_data,
    input  logic            ex_busy,
    output logic            ex_start,
    output logic [2:0]      ex_rs_index,
    output logic [DW-1:0]   ex_rs1_data,
    output logic [DW-1:0]   ex_rs2_data,
    output logic [3:0]      ex_func,
    output logic [TAGW-1:0] ex_rob_ind,
    output logic [RW-1:0]   ex_rd,
    input  logic            ex_done,
    input  logic [2:0]      ex_done_index,
    output logic [1:0]      count,
    output logic            illegal_func
);

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        EXEC  = 2'd3
    } state_e;

    typedef struct packed {
        state_e          st;
        logic [1:0]      age;
        logic [3:0]      func;
        logic [RW-1:0]   rd;
        logic [TAGW-1:0] rob;
        logic            v1;
        logic            v2;
        logic [DW-1:0]   d1;
        logic [DW-1:0]   d2;
        logic [TAGW-1:0] q1;
        logic [TAGW-1:0] q2;
    } entry_t;

    localparam logic [3:0] FUNC_MUL = 4'b0010;
    localparam logic [3:0] FUNC_DIV = 4'b0011;

    entry_t          ent_q [ENTRIES];
    entry_t          ent_d [ENTRIES];
    logic [1:0]      count_q, count_d;
    logic            ex_start_q, ex_start_d;
    logic [2:0]      ex_rs_index_q, ex_rs_index_d;
    logic [DW-1:0]   ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic [3:0]      ex_func_q, ex_func_d;
    logic [TAGW-1:0] ex_rob_q, ex_rob_d;
    logic [RW-1:0]   ex_rd_q, ex_rd_d;
    logic            illegal_q, illegal_d;

    logic            cand_found, any_exec, dispatch;
    logic [1:0]      cand_idx, cand_age;
    logic            free_hit;
    logic [1:0]      free_idx, free_age;
    logic            accept, func_ok, alloc, slot_found;
    logic [1:0]      alloc_idx;
    logic            byp1, byp2;

    assign iss_ready = (count_q < 2'(ENTRIES));

    // NOTE: every signal written here gets a default before any condition, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ent_d      = ent_q;
        cand_found = 1'b0;
        cand_idx   = '0;
        cand_age   = '0;
        any_exec   = 1'b0;
        free_hit   = 1'b0;
        free_idx   = '0;
        free_age   = '0;
        slot_found = 1'b0;
        alloc_idx  = '0;

        // Oldest READY entry, from registered state only.
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_q[i].st == EXEC) any_exec = 1'b1;
            if (ent_q[i].st == READY && (!cand_found || ent_q[i].age > cand_age)) begin
                cand_found = 1'b1;
                cand_idx   = 2'(i);
                cand_age   = ent_q[i].age;
            end
            // Completion for an entry that is not executing is ignored.
            if (ex_done && ex_done_index == 3'(i) && ent_q[i].st == EXEC) begin
                free_hit = 1'b1;
                free_idx = 2'(i);
                free_age = ent_q[i].age;
            end
            if (!slot_found && ent_q[i].st == FREE) begin
                slot_found = 1'b1;
                alloc_idx  = 2'(i);
            end
        end

        dispatch = cand_found && !ex_busy && !any_exec;
        accept   = iss_valid && iss_ready;
        func_ok  = (iss_func == FUNC_MUL) || (iss_func == FUNC_DIV);
        alloc    = accept && func_ok && slot_found;
        byp1     = !iss_v1 && cdb_valid && (iss_q1 == cdb_rob);
        byp2     = !iss_v2 && cdb_valid && (iss_q2 == cdb_rob);

        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_q[i].st != FREE) begin
                // Entries older than a freed one close the gap so that ages
                // stay 0..count-1 and the newest allocation never overflows.
                ent_d[i].age = ent_q[i].age
                             - 2'(free_hit && ent_q[i].age > free_age)
                             + 2'(alloc);
            end
            if (ent_q[i].st == WAIT && cdb_valid) begin
                if (!ent_q[i].v1 && ent_q[i].q1 == cdb_rob) begin
                    ent_d[i].v1 = 1'b1;
                    ent_d[i].d1 = cdb_data;
                end
                if (!ent_q[i].v2 && ent_q[i].q2 == cdb_rob) begin
                    ent_d[i].v2 = 1'b1;
                    ent_d[i].d2 = cdb_data;
                end
                if (ent_d[i].v1 && ent_d[i].v2) ent_d[i].st = READY;
            end
            if (dispatch && cand_idx == 2'(i)) ent_d[i].st = EXEC;
            if (free_hit && free_idx == 2'(i)) begin
                ent_d[i].st  = FREE;
                ent_d[i].age = '0;
            end
            if (alloc && alloc_idx == 2'(i)) begin
                ent_d[i].age  = '0;
                ent_d[i].func = iss_func;
                ent_d[i].rd   = iss_rd;
                ent_d[i].rob  = iss_rob;
                ent_d[i].v1   = iss_v1 || byp1;
                ent_d[i].v2   = iss_v2 || byp2;
                ent_d[i].d1   = byp1 ? cdb_data : iss_d1;
                ent_d[i].d2   = byp2 ? cdb_data : iss_d2;
                ent_d[i].q1   = iss_q1;
                ent_d[i].q2   = iss_q2;
                ent_d[i].st   = ((iss_v1 || byp1) && (iss_v2 || byp2)) ? READY : WAIT;
            end
        end

        count_d   = count_q + 2'(alloc) - 2'(free_hit);
        illegal_d = accept && !func_ok;

        // Payload registers hold until the next dispatch.
        ex_start_d    = dispatch;
        ex_rs_index_d = ex_rs_index_q;
        ex_rs1_d      = ex_rs1_q;
        ex_rs2_d      = ex_rs2_q;
        ex_func_d     = ex_func_q;
        ex_rob_d      = ex_rob_q;
        ex_rd_d       = ex_rd_q;
        if (dispatch) begin
            ex_rs_index_d = {1'b0, cand_idx};
            ex_rs1_d      = ent_q[cand_idx].d1;
            ex_rs2_d      = ent_q[cand_idx].d2;
            ex_func_d     = ent_q[cand_idx].func;
            ex_rob_d      = ent_q[cand_idx].rob;
            ex_rd_d       = ent_q[cand_idx].rd;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            // NOTE: the entry array is reset in full; it is small, and a stale
            // valid flag or tag surviving reset would corrupt a later wakeup.
            for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
            count_q       <= '0;
            ex_start_q    <= 1'b0;
            ex_rs_index_q <= '0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            ex_func_q     <= '0;
            ex_rob_q      <= '0;
            ex_rd_q       <= '0;
            illegal_q     <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) ent_q[i] <= ent_d[i];
            count_q       <= count_d;
            ex_start_q    <= ex_start_d;
            ex_rs_index_q <= ex_rs_index_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            ex_func_q     <= ex_func_d;
            ex_rob_q      <= ex_rob_d;
            ex_rd_q       <= ex_rd_d;
            illegal_q     <= illegal_d;
        end
    end

    assign count        = count_q;
    assign ex_start     = ex_start_q;
    assign ex_rs_index  = ex_rs_index_q;
    assign ex_rs1_data  = ex_rs1_q;
    assign ex_rs2_data  = ex_rs2_q;
    assign ex_func      = ex_func_q;
    assign ex_rob_ind   = ex_rob_q;
    assign ex_rd        = ex_rd_q;
    assign illegal_func = illegal_q;

endmodule
